snes_joypad_responder: RTL and testbench

Controller-side end of the SNES serial joypad interface. The console core drives strobe and per-port clocks, plus IOBit on port 2, and samples the 2-bit data lines per port. This block answers that protocol for two ports from parallel button vectors, with optional 4-player multitap emulation on port 2. It sits between the board's button/USB-HID decoders and the console core's JOY*_DI inputs. Everything runs on mclk.

---
 rtl/snes_joypad_responder.sv | 63 ++++++
 tb/tb_snes_joypad_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/snes_joypad_responder.sv
// snes_joypad_responder: two-port SNES serial pad responder with optional port-2 multitap
module snes_joypad_responder #(
  parameter bit DI_ACTIVE_LOW = 1'b1
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        joy_strb,
  input  logic        joy1_clk,
  input  logic        joy2_clk,
  input  logic        joy2_p6,
  input  logic        multitap_en,
  input  logic [11:0] pad1,
  input  logic [11:0] pad2,
  input  logic [11:0] pad3,
  input  logic [11:0] pad4,
  input  logic [11:0] pad5,
  output logic [1:0]  joy1_di,
  output logic [1:0]  joy2_di
);
  logic [4:0][11:0] pad;
  logic [4:0][15:0] sr, sr_n;
  logic [4:0] cnt1, cnt2, cnt1_n, cnt2_n, b;
  logic c1_q, c2_q, mt_q, e1, e2;
  logic [1:0] l1, l2;
  assign pad = {pad5, pad4, pad3, pad2, pad1};
  assign e1 = joy1_clk & ~c1_q & ~joy_strb;
  assign e2 = joy2_clk & ~c2_q & ~joy_strb;
  // Outputs register the next-state bit so data appears one cycle after the load/shift
  always_comb begin
    cnt1_n = joy_strb ? 5'd0 : (e1 && cnt1 != 5'd16) ? cnt1 + 5'd1 : cnt1;
    cnt2_n = joy_strb ? 5'd0 : (e2 && cnt2 != 5'd16) ? cnt2 + 5'd1 : cnt2;
    for (int k = 0; k < 5; k++) begin
      sr_n[k] = joy_strb ? {4'b0000, pad[k]} :
                (k == 0 ? e1 : k == 1 ? e2 : e2 & mt_q) ? {1'b1, sr[k][15:1]} : sr[k];
      b[k] = (k == 0 ? cnt1_n == 5'd16 : cnt2_n == 5'd16) | sr_n[k][0];
    end
    l1 = {1'b0, b[0]};
    l2 = !multitap_en ? {1'b0, b[1]} :
         joy_strb     ? {1'b1, joy2_p6 ? b[1] : b[3]} :
         joy2_p6      ? {b[2], b[1]} : {b[4], b[3]};
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      sr      <= '0;
      cnt1    <= '0;
      cnt2    <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      mt_q    <= 1'b0;
      joy1_di <= {2{DI_ACTIVE_LOW}};
      joy2_di <= {2{DI_ACTIVE_LOW}};
    end else begin
      sr      <= sr_n;
      cnt1    <= cnt1_n;
      cnt2    <= cnt2_n;
      c1_q    <= joy1_clk;
      c2_q    <= joy2_clk;
      mt_q    <= joy_strb ? multitap_en : mt_q;
      joy1_di <= l1 ^ {2{DI_ACTIVE_LOW}};
      joy2_di <= l2 ^ {2{DI_ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_snes_joypad_responder.sv
// tb_snes_joypad_responder: directed and table-driven checks of both output polarities
module tb_snes_joypad_responder;
  logic mclk = 1'b0;
  logic rst, joy_strb, joy1_clk, joy2_clk, joy2_p6, multitap_en;
  logic [11:0] pad1, pad2, pad3, pad4, pad5;
  logic [1:0] joy1_di, joy2_di, joy1_lg, joy2_lg;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic strb, c2, p6, mt;
    logic [1:0] e2;
  } vec_t;
  vec_t tbl[$];
  logic [20:0] seq;
  always #5 mclk = ~mclk;
  snes_joypad_responder #(.DI_ACTIVE_LOW(1'b1)) u_el (
    .mclk(mclk), .rst(rst), .joy_strb(joy_strb), .joy1_clk(joy1_clk), .joy2_clk(joy2_clk),
    .joy2_p6(joy2_p6), .multitap_en(multitap_en), .pad1(pad1), .pad2(pad2), .pad3(pad3),
    .pad4(pad4), .pad5(pad5), .joy1_di(joy1_di), .joy2_di(joy2_di)
  );
  snes_joypad_responder #(.DI_ACTIVE_LOW(1'b0)) u_lg (
    .mclk(mclk), .rst(rst), .joy_strb(joy_strb), .joy1_clk(joy1_clk), .joy2_clk(joy2_clk),
    .joy2_p6(joy2_p6), .multitap_en(multitap_en), .pad1(pad1), .pad2(pad2), .pad3(pad3),
    .pad4(pad4), .pad5(pad5), .joy1_di(joy1_lg), .joy2_di(joy2_lg)
  );
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [1:0] e1, input logic [1:0] e2);
    checks += 4;
    if (joy1_di !== ~e1) begin
      errors++;
      $display("FAIL %s joy1_di got %b want %b", name, joy1_di, ~e1);
    end
    if (joy2_di !== ~e2) begin
      errors++;
      $display("FAIL %s joy2_di got %b want %b", name, joy2_di, ~e2);
    end
    if (joy1_lg !== e1) begin
      errors++;
      $display("FAIL %s joy1_di(logical) got %b want %b", name, joy1_lg, e1);
    end
    if (joy2_lg !== e2) begin
      errors++;
      $display("FAIL %s joy2_di(logical) got %b want %b", name, joy2_lg, e2);
    end
  endtask
  function automatic logic fb(input logic [11:0] p, input int k);
    return k < 12 ? p[k] : (k >= 16);
  endfunction
  initial begin
    rst = 1'b1; joy_strb = 1'b0; joy1_clk = 1'b0; joy2_clk = 1'b0; joy2_p6 = 1'b0; multitap_en = 1'b0;
    pad1 = '0; pad2 = '0; pad3 = '0; pad4 = '0; pad5 = '0;
    tick; tick;
    chk("reset", 2'b00, 2'b00);
    rst = 1'b0;
    pad1 = 12'h001;
    joy_strb = 1'b1; tick;
    chk("load_b", 2'b01, 2'b00);
    tick;
    joy_strb = 1'b0; tick;
    chk("hold_b", 2'b01, 2'b00);
    for (int e = 1; e <= 16; e++) begin
      joy1_clk = 1'b1; tick;
      chk($sformatf("b_edge%0d", e), {1'b0, e == 16}, 2'b00);
      joy1_clk = 1'b0; tick;
    end
    seq = 21'h1F0A5A;
    pad1 = 12'hA5A;
    joy_strb = 1'b1; tick;
    joy_strb = 1'b0; tick;
    chk("a5a_bit0", {1'b0, seq[0]}, 2'b00);
    for (int e = 1; e <= 20; e++) begin
      if (e == 6) pad1 = 12'hFFF;
      joy1_clk = 1'b1; tick;
      chk($sformatf("a5a_edge%0d", e), {1'b0, seq[e]}, 2'b00);
      joy1_clk = 1'b0; tick;
    end
    pad1 = 12'h002;
    joy_strb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      joy1_clk = 1'b1; tick;
      chk($sformatf("strb_clk%0d", i), 2'b00, 2'b00);
      joy1_clk = 1'b0; tick;
      chk($sformatf("strb_clk%0d_lo", i), 2'b00, 2'b00);
    end
    joy_strb = 1'b0; tick;
    chk("strb_fall", 2'b00, 2'b00);
    joy1_clk = 1'b1; tick;
    chk("y_after_strb", 2'b01, 2'b00);
    joy1_clk = 1'b0; tick;
    pad1 = 12'h000; pad2 = 12'h001; pad3 = 12'h100; pad4 = 12'h800; pad5 = 12'h000;
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b01});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'b11});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b01});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'b00});
    for (int k = 1; k <= 17; k++) begin
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, {fb(12'h100, k), fb(12'h001, k)}});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, {fb(12'h000, k), fb(12'h800, k)}});
    end
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b01});
    foreach (tbl[i]) begin
      joy_strb = tbl[i].strb; joy2_clk = tbl[i].c2; joy2_p6 = tbl[i].p6; multitap_en = tbl[i].mt;
      tick;
      chk($sformatf("mt_row%0d", i), 2'b00, tbl[i].e2);
    end
    multitap_en = 1'b0; joy2_clk = 1'b0;
    pad1 = 12'hA5A;
    joy_strb = 1'b1; tick;
    joy_strb = 1'b0; tick;
    for (int e = 1; e <= 7; e++) begin
      joy1_clk = 1'b1; tick;
      joy1_clk = 1'b0; tick;
    end
    chk("pre_rst_bit7", {1'b0, seq[7]}, 2'b01);
    rst = 1'b1; tick;
    chk("mid_rst", 2'b00, 2'b00);
    rst = 1'b0; tick;
    chk("post_rst", 2'b00, 2'b00);
    joy_strb = 1'b1; tick;
    joy_strb = 1'b0; tick;
    chk("restart_bit0", {1'b0, seq[0]}, 2'b01);
    joy1_clk = 1'b1; tick;
    chk("restart_bit1", {1'b0, seq[1]}, 2'b01);
    joy1_clk = 1'b0; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
